dmem_arbiter: RTL and testbench

//  Shares the single-cycle core's one-port synchronous data memory between two requesters:

---
 rtl/arb_pkg.sv | 18 +
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/rr_pick2.sv | 16 +
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the data-memory arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int P_CORE = 0;
    localparam int P_LOAD = 1;

    // Width of the burst counter; at least one bit so MAX_BURST=1 still builds.
    function automatic int cnt_w(input int max_burst);
        return (max_burst <= 2) ? 1 : $clog2(max_burst);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - one requester port of the data-memory arbiter
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way priority picker with one-hot grant
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    // A lone requester always wins; on a tie the favoured port wins.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prio ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing the data memory between core and loader
module dmem_arbiter
    import arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    dmem_arbiter_if.slave p0,
    dmem_arbiter_if.slave p1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            CW       = cnt_w(MAX_BURST);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] cnt_nx;
    logic          prio;
    logic          prio_nx;
    logic [1:0]    req;
    logic [1:0]    pick_req;
    logic [1:0]    gnt;
    logic          owner;
    logic          keep;
    logic          fav;
    logic          rd_pend;
    logic          rd_port;
    logic          rv0;
    logic          rv1;

    assign req      = {p1.req, p0.req};
    assign pick_req = (en && rst) ? req : 2'b00;

    // Decide which port the picker favours: the owner while it may keep its burst, else the other.
    always_comb begin
        owner = (state == OWN1);
        keep  = 1'b0;
        fav   = prio;
        if (state != IDLE) begin
            keep = req[owner] && (!req[~owner] || (burst_cnt < CNT_LAST));
            fav  = keep ? owner : ~owner;
        end
    end

    rr_pick2 u_pick (
        .req  (pick_req),
        .prio (fav),
        .gnt  (gnt)
    );

    // Next owner, burst count and tie priority; everything holds while disabled.
    always_comb begin
        state_nx = state;
        cnt_nx   = burst_cnt;
        prio_nx  = prio;
        if (en) begin
            if (gnt == 2'b00) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else begin
                state_nx = gnt[P_LOAD] ? OWN1 : OWN0;
                if ((state != IDLE) && gnt[owner]) begin
                    cnt_nx = req[~owner] ? burst_cnt + CW'(1) : '0;
                end else begin
                    cnt_nx = '0;
                    if (state != IDLE) begin
                        prio_nx = owner;
                    end
                end
            end
        end
    end

    // Owner FSM state plus the read-return flag that tags next cycle's memory data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
            prio      <= 1'(P_CORE);
            rd_pend   <= 1'b0;
            rd_port   <= 1'b0;
        end else begin
            state     <= state_nx;
            burst_cnt <= cnt_nx;
            prio      <= prio_nx;
            rd_pend   <= mem_en & ~mem_we;
            rd_port   <= gnt[P_LOAD];
        end
    end

    // Route the granted port onto the memory bus; idle bus is driven to zero.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (gnt)
            2'b01: begin
                mem_we    = p0.we;
                mem_addr  = p0.addr;
                mem_wdata = p0.wdata;
            end
            2'b10: begin
                mem_we    = p1.we;
                mem_addr  = p1.addr;
                mem_wdata = p1.wdata;
            end
            default: begin
                mem_we    = 1'b0;
                mem_addr  = '0;
                mem_wdata = '0;
            end
        endcase
    end

    assign mem_en    = |gnt;
    assign rv0       = rd_pend & ~rd_port;
    assign rv1       = rd_pend & rd_port;
    assign p0.gnt    = gnt[P_CORE];
    assign p1.gnt    = gnt[P_LOAD];
    assign p0.rvalid = rv0;
    assign p1.rvalid = rv1;
    assign p0.rdata  = rv0 ? mem_rdata : '0;
    assign p1.rdata  = rv1 ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          en;
    logic          en_req;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) p0 ();
    dmem_arbiter_if #(.AW(AW), .DW(DW)) p1 ();

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .p0        (p0),
        .p1        (p1),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return {a, a, a, a} ^ 32'h5A5A_0000;
    endfunction

    // Synchronous one-port memory; unwritten words read a fixed pattern.
    logic [31:0] mem    [0:255];
    bit          mem_wr [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr[7:0]]    <= mem_wdata;
                mem_wr[mem_addr[7:0]] <= 1'b1;
            end else begin
                mem_rdata <= mem_wr[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
            end
        end
    end

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        q0[$];
    txn_t        q1[$];
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    int          grants[$];
    logic [31:0] sh    [0:255];
    bit          sh_wr [0:255];
    bit          due0;
    bit          due1;
    int          n_pass = 0;
    int          n_chk  = 0;
    int          seq [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic txn_t rd(input logic [31:0] a);
        txn_t t;
        t.we = 1'b0; t.addr = a; t.wdata = 32'h0;
        return t;
    endfunction

    function automatic txn_t wr(input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.we = 1'b1; t.addr = a; t.wdata = d;
        return t;
    endfunction

    function automatic int g(input int i);
        return (i < grants.size()) ? grants[i] : -1;
    endfunction

    task automatic drive();
        if (q0.size() > 0) begin
            p0.req = 1'b1; p0.we = q0[0].we; p0.addr = q0[0].addr; p0.wdata = q0[0].wdata;
        end else begin
            p0.req = 1'b0; p0.we = 1'b0; p0.addr = '0; p0.wdata = '0;
        end
        if (q1.size() > 0) begin
            p1.req = 1'b1; p1.we = q1[0].we; p1.addr = q1[0].addr; p1.wdata = q1[0].wdata;
        end else begin
            p1.req = 1'b0; p1.we = 1'b0; p1.addr = '0; p1.wdata = '0;
        end
    endtask

    // Check the memory bus for a grant and book the read result it will return.
    task automatic grant_seen(input int port, input txn_t t);
        check($sformatf("mem_bus%0d", port), {mem_en, mem_we, mem_addr, mem_wdata},
              {1'b1, t.we, t.addr, t.wdata});
        grants.push_back(port);
        if (t.we) begin
            sh[t.addr[7:0]]    = t.wdata;
            sh_wr[t.addr[7:0]] = 1'b1;
        end else if (port == 0) begin
            exp0.push_back(sh_wr[t.addr[7:0]] ? sh[t.addr[7:0]] : init_val(t.addr[7:0]));
        end else begin
            exp1.push_back(sh_wr[t.addr[7:0]] ? sh[t.addr[7:0]] : init_val(t.addr[7:0]));
        end
    endtask

    task automatic step();
        bit   nd0;
        bit   nd1;
        txn_t t;
        @(negedge clk);
        en = en_req;
        drive();
        #1;
        check("gnt_onehot", p0.gnt & p1.gnt, 0);
        check("rvalid0", p0.rvalid, due0);
        check("rvalid1", p1.rvalid, due1);
        if (p0.rvalid && exp0.size() > 0) check("rdata0", p0.rdata, exp0.pop_front());
        if (p1.rvalid && exp1.size() > 0) check("rdata1", p1.rdata, exp1.pop_front());
        if (!en) check("en_freeze", {p0.gnt, p1.gnt, mem_en}, 0);
        nd0 = 1'b0;
        nd1 = 1'b0;
        if (p0.gnt) begin
            if (q0.size() == 0) check("spurious_gnt0", 1, 0);
            else begin t = q0.pop_front(); grant_seen(0, t); nd0 = !t.we; end
        end
        if (p1.gnt) begin
            if (q1.size() == 0) check("spurious_gnt1", 1, 0);
            else begin t = q1.pop_front(); grant_seen(1, t); nd1 = !t.we; end
        end
        if (!p0.gnt && !p1.gnt) check("mem_idle", mem_en, 0);
        due0 = nd0;
        due1 = nd1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || due0 || due1) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", (q0.size() + q1.size() > 0) || due0 || due1, 0);
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_len"}, grants.size(), 12);
        for (int i = 0; i < 12; i++) check($sformatf("%s_%0d", tag, i), g(i), seq[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst    = 1'b0;
        en     = 1'b1;
        en_req = 1'b1;
        due0   = 1'b0;
        due1   = 1'b0;
        drive();

        // Reset held with both ports requesting: everything stays quiet.
        q0.push_back(rd(32'h4));
        q1.push_back(wr(32'h10, 32'hDEAD_BEEF));
        repeat (2) begin
            @(negedge clk);
            drive();
            #1;
            check("rst_quiet", {p0.gnt, p1.gnt, p0.rvalid, p1.rvalid, mem_en, mem_we}, 0);
            check("rst_data", {mem_addr, p0.rdata, p1.rdata}, 0);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        grants.delete();
        drain(20);
        check("t1_first", g(0), 0);
        check("t1_second", g(1), 1);
        step();

        // Port 0 reads back the word port 1 wrote during the reset test.
        q0.push_back(rd(32'h10));
        grants.delete();
        drain(10);
        check("t2_port", g(0), 0);
        step();

        // Port 1 write alone, then read-after-write to the same address.
        q1.push_back(wr(32'h20, 32'hCAFE_0001));
        q1.push_back(rd(32'h20));
        grants.delete();
        drain(10);
        check("t3_port", {g(0), g(1)}, {32'd1, 32'd1});
        step();

        // Continuous contention: bursts of MAX_BURST per port.
        for (int i = 0; i < 6; i++) begin
            q0.push_back(rd(32'h40 + i));
            q1.push_back(rd(32'h80 + i));
        end
        grants.delete();
        drain(40);
        check_seq("t4_seq");
        step();

        // Freeze mid-burst: owner and count resume unchanged.
        for (int i = 0; i < 6; i++) begin
            q0.push_back(rd(32'h50 + i));
            q1.push_back(wr(32'h90 + i, 32'h1234_0000 + i));
        end
        grants.delete();
        step();
        step();
        en_req = 1'b0;
        repeat (5) step();
        en_req = 1'b1;
        drain(40);
        check_seq("t5_seq");
        step();

        // Reset right after a port-1 read grant: the return is dropped at once.
        q1.push_back(rd(32'h30));
        step();
        check("t6_gnt1", g(grants.size() - 1), 1);
        q0.push_back(rd(32'h31));
        @(posedge clk);
        #1;
        check("t6_rv_before", p1.rvalid, 1);
        #1 rst = 1'b0;
        drive();
        #1;
        check("t6_async", {p1.rvalid, p0.rvalid, p1.rdata, p0.gnt, p1.gnt, mem_en}, 0);
        exp1.delete();
        due0 = 1'b0;
        due1 = 1'b0;
        @(negedge clk);
        #1;
        check("t6_rv_hold", {p1.rvalid, mem_en}, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        q1.push_back(rd(32'h32));
        grants.delete();
        drain(10);
        check("t6_after", {g(0), g(1)}, {32'd0, 32'd1});

        check("exp_empty", exp0.size() + exp1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
